rv_regfile: RTL and testbench
=============================

// Module: rv_regfile
// PURPOSE
//  - RV32I integer register file: 32 x 32-bit, two asynchronous read ports, one synchronous write port.
//  - Sits in the decode stage: rs1/rs2 read operands, rd written back from the writeback stage.
//  - x0 is hardwired to zero. All other registers clear on reset.
// PARAMETERS
//  - DATA_W   32   register width in bits
//  - ADDR_W   5    register index width
//  - NUM_REGS 32   register count, equal to 2**ADDR_W; localparam, not overridable
// PORTS
//  - clk         in   1       single clock; all state updates on rising edge
//  - rst         in   1       reset, synchronous, active-high
//  - reg_write   in   1       write enable
//  - read_reg1   in   ADDR_W  read port 1 index (rs1)
//  - read_reg2   in   ADDR_W  read port 2 index (rs2)
//  - write_reg   in   ADDR_W  write index (rd)
//  - write_data  in   DATA_W  write value
//  - read_data1  out  DATA_W  contents of read_reg1
//  - read_data2  out  DATA_W  contents of read_reg2
// BEHAVIOUR
//  - Reset: on a rising edge with rst=1, all registers x0..x31 become 0.
//    - rst has priority over a simultaneous write; the write is discarded.
//    - Outputs read 0 from the first edge after rst is asserted.
//  - Write: on a rising edge with rst=0 and reg_write=1, regs[write_reg] <= write_data.
//    - The new value is visible on the read ports immediately after that edge (write latency 1 edge).
//  - x0: writes with write_reg=0 are ignored.
//    - read_dataN is always 0 when read_regN=0, regardless of any bypass.
//  - Read: combinational.
//    - read_dataN = regs[read_regN], with no clock latency.
//    - Both ports may address the same register; each returns the same value.
//  - reg_write=0: no state changes. write_reg and write_data are don't-care.
//  - Same-cycle read of the register being written: behaviour depends on RF_BYPASS_EN (see CONFIGURATION).
//  - No X propagation: every register holds a defined value after the first reset.
// CONFIGURATION
//  - Macro RF_BYPASS_EN (write-to-read forwarding).
//  - Defined: if reg_write=1, write_reg!=0 and read_regN==write_reg, then read_dataN = write_data combinationally in the same cycle.
//  - Not defined (default): read_dataN returns the stored value; the new value appears only after the rising edge.
//  - Bypass is suppressed while rst=1.
// STRUCTURE
//  - Package rv_regfile_pkg holds:
//    - DATA_W, ADDR_W, NUM_REGS
//    - typedef word_t [DATA_W-1:0]
//    - typedef reg_idx_t [ADDR_W-1:0]
//    - localparam reg_idx_t ZERO_REG = '0
//  - One sub-module, rv_regfile_rd_port, instantiated twice. It contains:
//    - the index mux over the storage array
//    - the x0 zero-forcing
//    - the optional RF_BYPASS_EN forwarding mux
//  - Storage: one array of NUM_REGS words in a single always block. Reset loop and write decode live there.
// TESTING
//  - Reset and x0 behaviour:
//    - Assert rst for 1 edge -> read_data1/2 = 0 for every index 0..31.
//    - reg_write=1, write_reg=0, write_data=0xDEAD -> read_reg1=0 gives 0.
//  - reg_write=1, write_reg=20, write_data=1024, edge; then read_reg1=20 -> read_data1=1024.
//    - read_reg2=3 (never written) -> 0.
//  - reg_write=0, write_reg=15, write_data=1024, edge; then read_reg2=15 -> 0 (no write).
//  - Write 2048 to x2. Then reg_write=0, write_reg=2, write_data=4096, edge.
//    - read_reg2=2 -> 2048.
//    - Write 4096 to x30 -> read_reg1=30 gives 4096, read_reg2=2 gives 2048.
//  - Same-cycle read/write: write_reg=5, write_data=77, read_reg1=5 before the edge.
//    - With RF_BYPASS_EN -> read_data1=77 before the edge.
//    - Without RF_BYPASS_EN -> old value before the edge, 77 after the edge.
//  - Write x31=0xFFFFFFFF, then rst and reg_write asserted on the same edge -> x31 reads 0.

Source files
------------

// File: rtl/rv_regfile_pkg.sv
// Shared types and sizes for the RV32I integer register file.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
package rv_regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] reg_idx_t;

   localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/rv_regfile_rd_port.sv
// One combinational read port: index mux, optional forwarding, x0 forcing.
// Forwarding logic is present only when RF_BYPASS_EN is defined.
module rv_regfile_rd_port
   import rv_regfile_pkg::*;
(
   input  word_t    regs [NUM_REGS],
   input  reg_idx_t rd_idx,
`ifdef RF_BYPASS_EN
   input  logic     rst,
   input  logic     wr_en,
   input  reg_idx_t wr_idx,
   input  word_t    wr_data,
`endif
   output word_t    rd_data
);

   word_t stored;
   word_t fwd;

   assign stored = regs[rd_idx];

`ifdef RF_BYPASS_EN
   logic hit;

   assign hit = !rst && wr_en
             && (wr_idx != ZERO_REG)
             && (wr_idx == rd_idx);

   assign fwd = hit ? wr_data : stored;
`else
   assign fwd = stored;
`endif

   // x0 wins over any forwarded value
   assign rd_data = (rd_idx == ZERO_REG) ? '0 : fwd;

endmodule

// File: rtl/rv_regfile.sv
// RV32I register file: 32 x 32-bit, two async read ports, one sync write.
// Define RF_BYPASS_EN to forward the in-flight write to the read ports.
module rv_regfile
   import rv_regfile_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     reg_write,
   input  reg_idx_t read_reg1,
   input  reg_idx_t read_reg2,
   input  reg_idx_t write_reg,
   input  word_t    write_data,
   output word_t    read_data1,
   output word_t    read_data2
);

   word_t regs_q [NUM_REGS];

   // reset beats a simultaneous write; x0 is never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (reg_write && (write_reg != ZERO_REG)) begin
         regs_q[write_reg] <= write_data;
      end
   end

   rv_regfile_rd_port u_rd1 (
      .regs    (regs_q),
      .rd_idx  (read_reg1),
`ifdef RF_BYPASS_EN
      .rst     (rst),
      .wr_en   (reg_write),
      .wr_idx  (write_reg),
      .wr_data (write_data),
`endif
      .rd_data (read_data1)
   );

   rv_regfile_rd_port u_rd2 (
      .regs    (regs_q),
      .rd_idx  (read_reg2),
`ifdef RF_BYPASS_EN
      .rst     (rst),
      .wr_en   (reg_write),
      .wr_idx  (write_reg),
      .wr_data (write_data),
`endif
      .rd_data (read_data2)
   );

endmodule

// File: tb/tb_rv_regfile.sv
// Directed self-checking bench for rv_regfile.
// Same-cycle expectations follow RF_BYPASS_EN.
module tb_rv_regfile;
   import rv_regfile_pkg::*;

   logic     clk;
   logic     rst;
   logic     reg_write;
   reg_idx_t read_reg1;
   reg_idx_t read_reg2;
   reg_idx_t write_reg;
   word_t    write_data;
   word_t    read_data1;
   word_t    read_data2;

   int n_pass;
   int n_total;

   rv_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .reg_write  (reg_write),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input word_t got, input word_t exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // inputs change 1 time unit after the edge; reads sampled 1 unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input reg_idx_t idx, input word_t val);
      reg_write  = 1'b1;
      write_reg  = idx;
      write_data = val;
      tick();
      reg_write  = 1'b0;
   endtask

   initial begin
      word_t same_exp;
      n_pass     = 0;
      n_total    = 0;
      rst        = 1'b1;
      reg_write  = 1'b0;
      read_reg1  = '0;
      read_reg2  = '0;
      write_reg  = '0;
      write_data = '0;

      tick();
      rst = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         read_reg1 = reg_idx_t'(i);
         read_reg2 = reg_idx_t'(i);
         #1;
         check($sformatf("rst_rd1_x%0d", i), read_data1, 32'h0);
         check($sformatf("rst_rd2_x%0d", i), read_data2, 32'h0);
      end

      wr(5'd0, 32'h0000_DEAD);
      read_reg1 = 5'd0;
      #1;
      check("x0_write_ignored", read_data1, 32'h0);

      wr(5'd20, 32'd1024);
      read_reg1 = 5'd20;
      read_reg2 = 5'd3;
      #1;
      check("x20_written", read_data1, 32'd1024);
      check("x3_unwritten", read_data2, 32'h0);

      reg_write  = 1'b0;
      write_reg  = 5'd15;
      write_data = 32'd1024;
      tick();
      read_reg2 = 5'd15;
      #1;
      check("x15_no_we", read_data2, 32'h0);

      wr(5'd2, 32'd2048);
      reg_write  = 1'b0;
      write_reg  = 5'd2;
      write_data = 32'd4096;
      tick();
      read_reg2 = 5'd2;
      #1;
      check("x2_held", read_data2, 32'd2048);

      wr(5'd30, 32'd4096);
      read_reg1 = 5'd30;
      read_reg2 = 5'd2;
      #1;
      check("x30_written", read_data1, 32'd4096);
      check("x2_still", read_data2, 32'd2048);

      read_reg1 = 5'd30;
      read_reg2 = 5'd30;
      #1;
      check("same_idx_rd1", read_data1, 32'd4096);
      check("same_idx_rd2", read_data2, 32'd4096);

`ifdef RF_BYPASS_EN
      same_exp = 32'd77;
`else
      same_exp = 32'h0;
`endif
      reg_write  = 1'b1;
      write_reg  = 5'd5;
      write_data = 32'd77;
      read_reg1  = 5'd5;
      read_reg2  = 5'd0;
      #1;
      check("x5_before_edge", read_data1, same_exp);
      check("x0_no_bypass", read_data2, 32'h0);
      tick();
      reg_write = 1'b0;
      #1;
      check("x5_after_edge", read_data1, 32'd77);

      reg_write  = 1'b1;
      write_reg  = 5'd0;
      write_data = 32'd55;
      read_reg1  = 5'd0;
      #1;
      check("x0_wr_same_cycle", read_data1, 32'h0);
      reg_write = 1'b0;

      wr(5'd31, 32'hFFFF_FFFF);
      read_reg1 = 5'd31;
      #1;
      check("x31_written", read_data1, 32'hFFFF_FFFF);

      rst        = 1'b1;
      reg_write  = 1'b1;
      write_reg  = 5'd31;
      write_data = 32'h0000_1234;
      #1;
      check("x31_rst_no_bypass", read_data1, 32'hFFFF_FFFF);
      tick();
      rst       = 1'b0;
      reg_write = 1'b0;
      read_reg2 = 5'd20;
      #1;
      check("x31_rst_beats_wr", read_data1, 32'h0);
      check("x20_cleared", read_data2, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
